ball_hit_tracker: RTL

- Parametrised successor to the frame-locked collision detector. Detects ball-ball, ball-wall and ball-hole hits from per-pixel draw requests for NUM_BALLS balls.
- Suppresses repeat reports through a per-pair slot table and per-ball wall locks, each aged in frames.
- Emits single-cycle hit pulses with encoded ball IDs to the movement/collision-response blocks.
- Sits between the VGA object drawers and the ball physics units.

---
 rtl/ball_hit_tracker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ball_hit_tracker.sv
// Ball-ball, ball-wall and ball-hole hit tracker with frame-aged repeat suppression.
// Optional HIT_STATS_EN adds a saturating count of accepted pair hits.
module ball_hit_tracker #(
    parameter int NUM_BALLS   = 4,
    parameter int PAIR_SLOTS  = 4,
    parameter int HOLD_FRAMES = 2,
    parameter int ID_W        = $clog2(NUM_BALLS)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 new_game,
    input  logic [1:0]           Table_DR,
    input  logic                 Hole_DR,
    input  logic [NUM_BALLS-1:0] Balls_DR_VEC,
    output logic                 collision,
    output logic [NUM_BALLS-1:0] balls_in_game,
    output logic                 pair_hit,
    output logic [ID_W-1:0]      pair_id_a,
    output logic [ID_W-1:0]      pair_id_b,
    output logic [NUM_BALLS-1:0] ballwall_collide,
    output logic [1:0]           collided_wall,
    output logic [NUM_BALLS-1:0] ballhole_collide,
    output logic                 pair_overflow
`ifdef HIT_STATS_EN
    ,
    output logic [15:0]          hit_count
`endif
);

    localparam int AGE_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(HOLD_FRAMES - 1);

    logic [PAIR_SLOTS-1:0] slot_vld;
    logic [ID_W-1:0]       slot_a   [PAIR_SLOTS];
    logic [ID_W-1:0]       slot_b   [PAIR_SLOTS];
    logic [AGE_W-1:0]      slot_age [PAIR_SLOTS];
    logic [NUM_BALLS-1:0]  lock;
    logic [AGE_W-1:0]      lock_age [NUM_BALLS];

    logic [NUM_BALLS-1:0]  act_p0, rest_p0, wall_new_p0;
    logic [ID_W-1:0]       a_p0, b_p0;
    logic                  pair_det_p0, has_free_p0, hit_new_p0, drop_p0, hole_det_p0;
    logic [PAIR_SLOTS-1:0] match_p0, alloc_p0;

    // Stage p0: combinational detection against the pre-update table state
    assign act_p0 = Balls_DR_VEC & balls_in_game;

    always_comb begin
        a_p0    = '0;
        b_p0    = '0;
        rest_p0 = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--)
            if (act_p0[i]) a_p0 = ID_W'(i);
        rest_p0 = act_p0 & ~(NUM_BALLS'(1) << a_p0);
        for (int i = NUM_BALLS - 1; i >= 0; i--)
            if (rest_p0[i]) b_p0 = ID_W'(i);
    end

    assign pair_det_p0 = |rest_p0;

    always_comb begin
        match_p0    = '0;
        alloc_p0    = '0;
        has_free_p0 = 1'b0;
        for (int s = 0; s < PAIR_SLOTS; s++) begin
            match_p0[s] = slot_vld[s] && (slot_a[s] == a_p0) && (slot_b[s] == b_p0);
            if (!slot_vld[s] && !has_free_p0) begin
                alloc_p0[s] = 1'b1;
                has_free_p0 = 1'b1;
            end
        end
    end

    assign hit_new_p0  = pair_det_p0 && !(|match_p0) && has_free_p0;
    assign drop_p0     = pair_det_p0 && !(|match_p0) && !has_free_p0;
    assign wall_new_p0 = (Table_DR != 2'b00) ? (act_p0 & ~lock) : '0;
    assign hole_det_p0 = Hole_DR && (|act_p0);
    assign collision   = pair_det_p0 || ((Table_DR != 2'b00) && (|act_p0));

    // Stage p1: registered pulses, table/lock update and frame aging
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            balls_in_game    <= '1;
            pair_hit         <= 1'b0;
            pair_id_a        <= '0;
            pair_id_b        <= '0;
            ballwall_collide <= '0;
            collided_wall    <= 2'b00;
            ballhole_collide <= '0;
            pair_overflow    <= 1'b0;
            slot_vld         <= '0;
            lock             <= '0;
            for (int s = 0; s < PAIR_SLOTS; s++) begin
                slot_a[s]   <= '0;
                slot_b[s]   <= '0;
                slot_age[s] <= '0;
            end
            for (int i = 0; i < NUM_BALLS; i++) lock_age[i] <= '0;
        end else if (new_game) begin
            balls_in_game    <= '1;
            pair_hit         <= 1'b0;
            pair_id_a        <= '0;
            pair_id_b        <= '0;
            ballwall_collide <= '0;
            collided_wall    <= 2'b00;
            ballhole_collide <= '0;
            pair_overflow    <= 1'b0;
            slot_vld         <= '0;
            lock             <= '0;
            for (int s = 0; s < PAIR_SLOTS; s++) slot_age[s] <= '0;
            for (int i = 0; i < NUM_BALLS; i++) lock_age[i] <= '0;
        end else begin
            pair_hit         <= hit_new_p0;
            pair_id_a        <= hit_new_p0 ? a_p0 : '0;
            pair_id_b        <= hit_new_p0 ? b_p0 : '0;
            ballwall_collide <= wall_new_p0;
            collided_wall    <= (|wall_new_p0) ? Table_DR : 2'b00;
            ballhole_collide <= hole_det_p0 ? act_p0 : '0;
            if (hole_det_p0) balls_in_game <= balls_in_game & ~act_p0;

            if (drop_p0)           pair_overflow <= 1'b1;
            else if (startOfFrame) pair_overflow <= 1'b0;

            // A refresh or allocation this cycle wins over frame aging
            for (int s = 0; s < PAIR_SLOTS; s++) begin
                if (pair_det_p0 && match_p0[s]) begin
                    slot_age[s] <= '0;
                end else if (hit_new_p0 && alloc_p0[s]) begin
                    slot_vld[s] <= 1'b1;
                    slot_a[s]   <= a_p0;
                    slot_b[s]   <= b_p0;
                    slot_age[s] <= '0;
                end else if (startOfFrame && slot_vld[s]) begin
                    if (slot_age[s] == AGE_LAST) begin
                        slot_vld[s] <= 1'b0;
                        slot_age[s] <= '0;
                    end else begin
                        slot_age[s] <= slot_age[s] + 1'b1;
                    end
                end
            end

            for (int i = 0; i < NUM_BALLS; i++) begin
                if (wall_new_p0[i]) begin
                    lock[i]     <= 1'b1;
                    lock_age[i] <= '0;
                end else if (startOfFrame && lock[i]) begin
                    if (lock_age[i] == AGE_LAST) begin
                        lock[i]     <= 1'b0;
                        lock_age[i] <= '0;
                    end else begin
                        lock_age[i] <= lock_age[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef HIT_STATS_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            hit_count <= '0;
        else if (new_game)
            hit_count <= '0;
        else if (hit_new_p0 && (hit_count != 16'hFFFF))
            hit_count <= hit_count + 16'd1;
    end
`endif

endmodule
